// File: rtl/serial_word_collector.sv
// serial_word_collector: MSB-first serial-to-parallel word assembler with a
// valid/ready output register and a sticky overrun flag for dropped words.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d, word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic overrun_q, overrun_d, complete, load;
  assign word     = {shift_q[WIDTH-2:0], d};
  assign complete = en && !clr && cnt_q == CNT_W'(WIDTH-1);
  // A finished word is taken only if the output slot is empty or being drained on this edge.
  assign load     = complete && (state_q == EMPTY || out_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == EMPTY) state_d = complete ? FULL : EMPTY;
    else                  state_d = (complete || !out_ready) ? FULL : EMPTY;
  end
  always_comb begin
    shift_d   = clr ? '0 : en ? word : shift_q;
    cnt_d     = clr ? '0 : !en ? cnt_q : complete ? '0 : cnt_q + CNT_W'(1);
    data_d    = load ? word : data_q;
    overrun_d = overrun_q || (complete && !load);
  end
  always_comb begin
    out_valid = state_q == FULL;
    out_data  = data_q;
    bit_count = cnt_q;
    overrun   = overrun_q;
  end
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: directed test-plan sequences plus random traffic,
// checked every cycle against a word-level model of the collector.
module tb_serial_word_collector;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, d = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] bit_count;
  logic out_valid, overrun;
  int n_cmp = 0, n_bad = 0;
  int m_part, m_cnt, m_data, w;
  bit m_valid, m_ovr, comp;

  serial_word_collector #(.WIDTH(8), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bit_count(bit_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Model: the partial word is a number built up as value*2+bit; the output is one slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_part = 0; m_cnt = 0; m_data = 0; m_valid = 0; m_ovr = 0;
    end else begin
      comp = en && !clr && m_cnt == 7;
      w = (m_part * 2 + int'(d)) % 256;
      if (clr) begin
        m_part = 0; m_cnt = 0;
      end else if (en) begin
        m_part = w; m_cnt = (m_cnt + 1) % 8;
      end
      if (comp) begin
        if (!m_valid || out_ready) begin m_data = w; m_valid = 1; end
        else m_ovr = 1;
      end else if (m_valid && out_ready) m_valid = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model out_data", int'(out_data), m_data);
    chk("model out_valid", int'(out_valid), int'(m_valid));
    chk("model bit_count", int'(bit_count), m_cnt);
    chk("model overrun", int'(overrun), int'(m_ovr));
  end

  task automatic step(input bit e, input bit b, input bit c, input bit r);
    en = e; d = b; clr = c; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Sends 8 bits MSB first; ready is r except on the last bit's edge where it is r_last.
  task automatic send(input logic [7:0] v, input bit gap, input bit r, input bit r_last);
    int held;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, v[i], 1'b0, i == 0 ? r_last : r);
      if (gap && i != 0) begin
        held = int'(bit_count);
        step(1'b0, ~v[i], 1'b0, r);
        chk("gap hold", int'(bit_count), held);
      end
    end
  endtask

  initial begin
    logic [7:0] pat;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset bit_count", int'(bit_count), 0);
    rst_n = 1'b1;
    // Basic word with bit_count trace
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, pat[i], 1'b0, 1'b1);
      if (i != 0) chk("basic count", int'(bit_count), 8 - i);
    end
    chk("basic data", int'(out_data), 'hB2);
    chk("basic valid", int'(out_valid), 1);
    chk("basic count wrap", int'(bit_count), 0);
    // Gapped strobes (first edge also accepts the pending word)
    send(8'hB2, 1'b1, 1'b1, 1'b0);
    chk("gapped data", int'(out_data), 'hB2);
    chk("gapped valid", int'(out_valid), 1);
    // Back-to-back with accept on the completion edge
    send(8'hFF, 1'b0, 1'b0, 1'b1);
    chk("b2b data", int'(out_data), 'hFF);
    chk("b2b valid", int'(out_valid), 1);
    chk("b2b overrun", int'(overrun), 0);
    // Overrun
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    chk("ovr data", int'(out_data), 'h0F);
    chk("ovr flag", int'(overrun), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr drain valid", int'(out_valid), 0);
    chk("ovr sticky", int'(overrun), 1);
    // Clear mid-word with a word pending
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre clr count", int'(bit_count), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr count", int'(bit_count), 0);
    chk("clr keeps data", int'(out_data), 'h3C);
    chk("clr keeps valid", int'(out_valid), 1);
    send(8'h5A, 1'b0, 1'b1, 1'b1);
    chk("clr then word", int'(out_data), 'h5A);
    // Asynchronous reset mid-word and mid-handshake
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async out_data", int'(out_data), 0);
    chk("async out_valid", int'(out_valid), 0);
    chk("async bit_count", int'(bit_count), 0);
    chk("async overrun", int'(overrun), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 31) == 0, 1'($urandom));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Sits directly downstream of the enabled D flip-flop stage. That stage's q output and its enable strobe feed this block.
- On each enabled clock, the block shifts in one serial bit, MSB first. After WIDTH bits it presents a parallel word under a valid/ready handshake.
- It also flags words lost because the consumer stalled.
- It is the serial-to-parallel stage ahead of the register-file/ALU consumers.

Parameters:
- WIDTH, 8, bits per assembled word (legal range 2..32).
- CNT_W, 5, width of the bit counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  bit strobe; d is sampled on rising clk only when en=1.
- d  input  1  serial data bit (q of the upstream flip-flop).
- clr  input  1  synchronous clear of the partial word; does not touch the output side.
- out_data  output  WIDTH  assembled word; first received bit is at [WIDTH-1].
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid&&out_ready at a rising edge.
- bit_count  output  CNT_W  number of bits held in the partial word (0..WIDTH-1).
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately. During reset:
  - shift register = 0
  - bit_count = 0
  - out_data = 0
  - out_valid = 0
  - overrun = 0
- Release of reset is synchronous to the next rising clk.
- Shift: on a rising edge with en=1 and clr=0:
  - shift_reg <= {shift_reg[WIDTH-2:0], d}
  - bit_count increments.
- Idle: en=0 leaves the shift register and counter unchanged (hold).
- Completion: an edge with en=1, clr=0 and bit_count==WIDTH-1 is a completion edge.
  - The word {shift_reg[WIDTH-2:0], d} is the completed word.
  - bit_count wraps to 0 on that same edge.
- Output load, on a completion edge:
  - If out_valid=0, or out_valid=1 with out_ready=1 on that same edge: out_data <= completed word and out_valid <= 1. Latency is 0 cycles after the last bit's edge: out_valid is high immediately after that edge.
  - If out_valid=1 and out_ready=0: the completed word is discarded, out_data keeps the old word, and overrun <= 1.
- Handshake: on an edge with out_valid&&out_ready and no completion, out_valid <= 0.
  - out_data holds its last value; it is don't-care to the consumer but must not change.
- While out_valid=1, out_data is stable until the accepting edge.
- clr=1 at an edge:
  - bit_count <= 0 and shift_reg <= 0.
  - clr has priority over en; the bit present on that edge is dropped.
  - clr does not affect out_data, out_valid or overrun.
- overrun is cleared only by rst_n.
- The output side is a state machine with two states:
  - EMPTY to FULL on a completion edge.
  - FULL to EMPTY on a handshake edge without completion.
  - FULL stays FULL on a completion edge together with a handshake (new word loaded).
  - FULL stays FULL on a completion edge without a handshake (overrun).
- Reset asserted mid-word or mid-handshake aborts everything; no partial word survives.
- No combinational path from any input to any output.

Test Plan:
- Reset behaviour: hold rst_n=0 for 2 cycles, then assert rst_n=0 asynchronously mid-cycle. Required: all outputs are 0 immediately, with no clock edge needed.
- Basic word: WIDTH=8, out_ready=1, en=1, d sequence 1,0,1,1,0,0,1,0. Required: after the 8th edge, out_data=8'hB2 and out_valid=1; bit_count goes 1..7, then 0.
- Gapped strobes: the same bits with en=0 on alternate cycles. Required: identical word 8'hB2, and bit_count holds during the gaps.
- Back-to-back with simultaneous accept: out_ready=0 while word 8'hB2 is pending; send 0xFF; raise out_ready on the completion edge. Required: out_data=8'hFF, out_valid stays 1, overrun=0.
- Overrun: out_ready=0, send 8'h0F, then 8'hF0. Required: out_data stays 8'h0F and overrun=1. A later out_ready=1 gives out_valid=0, and overrun stays 1.
- Clear mid-word: shift 3 bits, pulse clr=1 with en=1, then send 8'h5A. Required: bit_count=0 after clr, out_data=8'h5A, and the pending output word is unaffected by clr.
